// File: rtl/perf_counter_initiator.sv
// perf_counter_initiator
// Avalon-MM initiator that drives a two-section performance counter block:
// start/stop/clear requests become single-cycle writes, and a dump request
// reads back a 64-bit time counter (torn-read safe) plus a 32-bit event count.
// Optional feature: define PERF_INIT_CLEAR_EN to enable the global clear write.
module perf_counter_initiator #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  start_req,
    input  logic [1:0]  stop_req,
    input  logic        clear_req,
    input  logic        dump_req,
    input  logic        dump_sel,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_sel,
    output logic [63:0] res_time,
    output logic [31:0] res_events,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic        avm_begintransfer,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_HI1,
        RD_LO,
        RD_HI2,
        RD_EV,
        RESULT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [2:0]  addr_d;
    logic        dsel_q;

    logic [1:0]  pend_start;
    logic [1:0]  pend_stop;
    logic        pend_dump;
    logic        pend_sel;
    logic        pend_clear;

    logic [1:0]  svc_start;
    logic [1:0]  svc_stop;
    logic        svc_dump;

    logic [31:0] hi1_q;
    logic [31:0] lo_q;

    logic        is_rd;
    logic        phase_last;

    assign is_rd      = (state_q == RD_HI1) || (state_q == RD_LO) ||
                        (state_q == RD_HI2) || (state_q == RD_EV);
    // The phase ends READ_LATENCY cycles after the read strobe, when data is valid.
    assign phase_last = is_rd && (cnt_q == 2'(READ_LATENCY));

    assign avm_write         = (state_q == WR);
    assign avm_read          = is_rd && (cnt_q == 2'd0);
    assign avm_begintransfer = avm_write || avm_read;

    assign busy = (state_q != IDLE) || (|pend_stop) || (|pend_start) ||
                  pend_dump || pend_clear;

    // Next state, request selection in IDLE and address of the next transfer
    always_comb begin
        state_d   = state_q;
        addr_d    = avm_address;
        svc_start = 2'b00;
        svc_stop  = 2'b00;
        svc_dump  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_clear) begin
                    state_d = WR;
                    addr_d  = 3'd0;
                end else if (pend_stop[0]) begin
                    state_d     = WR;
                    svc_stop[0] = 1'b1;
                    addr_d      = 3'd0;
                end else if (pend_stop[1]) begin
                    state_d     = WR;
                    svc_stop[1] = 1'b1;
                    addr_d      = 3'd4;
                end else if (pend_start[0]) begin
                    state_d      = WR;
                    svc_start[0] = 1'b1;
                    addr_d       = 3'd1;
                end else if (pend_start[1]) begin
                    state_d      = WR;
                    svc_start[1] = 1'b1;
                    addr_d       = 3'd5;
                end else if (pend_dump) begin
                    state_d  = RD_HI1;
                    svc_dump = 1'b1;
                    addr_d   = {pend_sel, 2'b01};
                end
            end
            WR: state_d = IDLE;
            RD_HI1: begin
                if (phase_last) begin
                    state_d = RD_LO;
                    addr_d  = {dsel_q, 2'b00};
                end
            end
            RD_LO: begin
                if (phase_last) begin
                    state_d = RD_HI2;
                    addr_d  = {dsel_q, 2'b01};
                end
            end
            RD_HI2: begin
                if (phase_last) begin
                    // A changed high word means the low word may have wrapped: re-read it.
                    if (avm_readdata != hi1_q) begin
                        state_d = RD_LO;
                        addr_d  = {dsel_q, 2'b00};
                    end else begin
                        state_d = RD_EV;
                        addr_d  = {dsel_q, 2'b10};
                    end
                end
            end
            RD_EV: begin
                if (phase_last) state_d = RESULT;
            end
            RESULT: begin
                if (res_valid && res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, read-phase counter, address register and latched section
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            avm_address <= 3'd0;
            dsel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (is_rd && !phase_last) ? cnt_q + 2'd1 : 2'd0;
            avm_address <= addr_d;
            if (svc_dump) dsel_q <= pend_sel;
        end
    end

    // Sticky pending bits; a stop in the same cycle as a start cancels that start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_start <= 2'b00;
            pend_stop  <= 2'b00;
            pend_dump  <= 1'b0;
            pend_sel   <= 1'b0;
        end else begin
            pend_stop  <= (pend_stop & ~svc_stop) | stop_req;
            pend_start <= (pend_start & ~svc_start) | (start_req & ~stop_req);
            pend_dump  <= (pend_dump & ~svc_dump) | dump_req;
            if (dump_req && (!pend_dump || svc_dump)) pend_sel <= dump_sel;
        end
    end

`ifdef PERF_INIT_CLEAR_EN
    logic wr_clr_q;

    // Clear pending bit; it has top priority so leaving IDLE always services it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_clear <= 1'b0;
            wr_clr_q   <= 1'b0;
        end else begin
            pend_clear <= ((state_q == IDLE) ? 1'b0 : pend_clear) | clear_req;
            if (state_q == IDLE) wr_clr_q <= pend_clear;
        end
    end

    assign avm_writedata = (avm_write && wr_clr_q) ? 32'd1 : 32'd0;
`else
    logic unused_clear;

    assign unused_clear  = clear_req;
    assign pend_clear    = 1'b0;
    assign avm_writedata = 32'd0;
`endif

    // Read-back words captured at the end of each read phase
    always_ff @(posedge clk) begin
        if (phase_last) begin
            case (state_q)
                RD_HI1:  hi1_q <= avm_readdata;
                RD_LO:   lo_q  <= avm_readdata;
                RD_HI2:  hi1_q <= avm_readdata;
                default: ;
            endcase
        end
    end

    // Result register: loaded on entry to RESULT, held until accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid  <= 1'b0;
            res_sel    <= 1'b0;
            res_time   <= 64'd0;
            res_events <= 32'd0;
        end else begin
            if ((state_q == RD_EV) && phase_last) begin
                res_valid  <= 1'b1;
                res_sel    <= dsel_q;
                res_time   <= {hi1_q, lo_q};
                res_events <= avm_readdata;
            end else if ((state_q == RESULT) && res_ready) begin
                res_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_initiator.sv
// Testbench for perf_counter_initiator: directed requests, an Avalon-MM slave
// model with configurable read latency, and a scoreboard of expected transfers
// and results checked by an independent monitor.
module tb_perf_counter_initiator;

    localparam int RL = 3;

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic        sel;
        logic [63:0] tim;
        logic [31:0] ev;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  start_req = 2'b00;
    logic [1:0]  stop_req = 2'b00;
    logic        clear_req = 1'b0;
    logic        dump_req = 1'b0;
    logic        dump_sel = 1'b0;
    logic        res_ready = 1'b1;
    logic        busy;
    logic        res_valid;
    logic        res_sel;
    logic [63:0] res_time;
    logic [31:0] res_events;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic        avm_begintransfer;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          rd_seen = 0;
    int          rd_left = 0;
    logic [2:0]  cur_rd_addr = 3'd0;
    int          rd_stamps[$];
    xfer_t       exp_q[$];
    res_t        res_q[$];
    logic [31:0] rd_resp[$];
    xfer_t       mon_x;
    res_t        mon_r;

    logic [31:0] pipe_d [RL];
    logic        pipe_v [RL];

    perf_counter_initiator #(.READ_LATENCY(RL)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_req         (start_req),
        .stop_req          (stop_req),
        .clear_req         (clear_req),
        .dump_req          (dump_req),
        .dump_sel          (dump_sel),
        .busy              (busy),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_sel           (res_sel),
        .res_time          (res_time),
        .res_events        (res_events),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_begintransfer (avm_begintransfer),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < RL; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 32'd0;
        end
    end

    function automatic logic [31:0] pop_resp();
        if (rd_resp.size() == 0) return 32'hBAD0_0000;
        return rd_resp.pop_front();
    endfunction

    // Slave model: read data is valid only in the cycle RL cycles after the strobe
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pipe_v[0] <= avm_read;
        pipe_d[0] <= avm_read ? pop_resp() : 32'd0;
        for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign avm_readdata = (pipe_v[RL-1] === 1'b1) ? pipe_d[RL-1] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_w(input logic [2:0] a, input logic [31:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    task automatic push_r(input logic [2:0] a, input logic [31:0] d);
        exp_q.push_back('{1'b0, a, 32'd0});
        rd_resp.push_back(d);
    endtask

    task automatic pulse(input logic [1:0] st, input logic [1:0] sp,
                         input logic cl, input logic dm, input logic sl);
        @(posedge clk); #1;
        start_req = st; stop_req = sp; clear_req = cl; dump_req = dm; dump_sel = sl;
        @(posedge clk); #1;
        start_req = 2'b00; stop_req = 2'b00; clear_req = 1'b0; dump_req = 1'b0; dump_sel = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            ok = (busy == 1'b0) && (exp_q.size() == 0) && (res_q.size() == 0);
            n++;
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_sel"}, res_sel, 0);
        chk({pfx, "_res_time"}, res_time, 0);
        chk({pfx, "_res_events"}, res_events, 0);
        chk({pfx, "_avm_address"}, avm_address, 0);
        chk({pfx, "_avm_write"}, avm_write, 0);
        chk({pfx, "_avm_read"}, avm_read, 0);
        chk({pfx, "_avm_bt"}, avm_begintransfer, 0);
        chk({pfx, "_avm_wdata"}, avm_writedata, 0);
    endtask

    // Monitor: pops expectations whenever the DUT starts a transfer or hands over a result
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_left = 0;
        end else begin
            if (!avm_write) chk("wdata_idle", avm_writedata, 32'd0);
            if (rd_left > 0) begin
                chk("rd_addr_hold", avm_address, cur_rd_addr);
                chk("rd_strobe_once", {avm_read, avm_begintransfer, avm_write}, 3'b000);
                rd_left--;
            end else if (avm_begintransfer) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_xfer: actual addr=%0d wr=%0b rd=%0b required none",
                             avm_address, avm_write, avm_read);
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("xfer_kind", {avm_write, avm_read}, mon_x.is_wr ? 2'b10 : 2'b01);
                    chk("xfer_addr", avm_address, mon_x.addr);
                    if (mon_x.is_wr) chk("xfer_wdata", avm_writedata, mon_x.data);
                end
                if (avm_read) begin
                    cur_rd_addr = avm_address;
                    rd_left     = RL;
                    rd_stamps.push_back(cyc);
                    rd_seen++;
                end
            end else if (avm_write || avm_read) begin
                chk("strobe_without_bt", avm_begintransfer, 1'b1);
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: actual sel=%0d time=%0h required none",
                             res_sel, res_time);
                end else begin
                    mon_r = res_q.pop_front();
                    chk("res_sel", res_sel, mon_r.sel);
                    chk("res_time", res_time, mon_r.tim);
                    chk("res_events", res_events, mon_r.ev);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;

        // Reset state
        #12;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Start section 0, idle, then stop section 0
        push_w(3'd1, 32'd0);
        pulse(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("busy_pending", busy, 1'b1);
        wait_done("s1_start_done", 50);
        repeat (10) @(posedge clk);
        push_w(3'd0, 32'd0);
        pulse(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_done("s1_stop_done", 50);

        // Start 11 with stop 01 in one cycle: start0 dropped, stop0 before start1
        push_w(3'd0, 32'd0);
        push_w(3'd5, 32'd0);
        pulse(2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
        wait_done("s2_done", 50);

`ifdef PERF_INIT_CLEAR_EN
        // Clear outranks a simultaneous stop1
        push_w(3'd0, 32'd1);
        push_w(3'd4, 32'd0);
        pulse(2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
        wait_done("clr_done", 50);
`endif

        // Dump section 1; a start arriving mid-dump waits until the result is taken
        push_r(3'd5, 32'd5);
        push_r(3'd4, 32'h10);
        push_r(3'd5, 32'd5);
        push_r(3'd6, 32'd3);
        push_w(3'd1, 32'd0);
        res_q.push_back('{1'b1, 64'h0000_0005_0000_0010, 32'd3});
        pulse(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        pulse(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        wait_done("s3_done", 200);

        // Dump section 0 with high word changing between the two reads
        push_r(3'd1, 32'd5);
        push_r(3'd0, 32'h20);
        push_r(3'd1, 32'd6);
        push_r(3'd0, 32'h21);
        push_r(3'd1, 32'd6);
        push_r(3'd2, 32'd7);
        res_q.push_back('{1'b0, 64'h0000_0006_0000_0021, 32'd7});
        pulse(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        wait_done("s4_done", 300);

        // Phase length and result hold under backpressure
        rd_stamps.delete();
        res_ready = 1'b0;
        push_r(3'd1, 32'd1);
        push_r(3'd0, 32'd2);
        push_r(3'd1, 32'd1);
        push_r(3'd2, 32'd9);
        res_q.push_back('{1'b0, 64'h0000_0001_0000_0002, 32'd9});
        pulse(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (n < 200 && res_valid !== 1'b1) begin
            @(negedge clk); #1;
            n++;
        end
        chk("s5_res_valid_seen", res_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("s5_hold_valid", res_valid, 1'b1);
            chk("s5_hold_time", res_time, 64'h0000_0001_0000_0002);
            chk("s5_hold_events", res_events, 32'd9);
            chk("s5_hold_sel", res_sel, 1'b0);
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done("s5_done", 50);
        chk("s5_valid_drop", res_valid, 1'b0);
        chk("s5_read_count", rd_stamps.size(), 4);
        if (rd_stamps.size() == 4) begin
            for (int k = 1; k < 4; k++)
                chk("s5_phase_len", rd_stamps[k] - rd_stamps[k-1], RL + 1);
        end

        // Clear and start during a dump, then reset during RD_EV: nothing replays
        base = rd_seen;
        push_r(3'd5, 32'd5);
        push_r(3'd4, 32'h10);
        push_r(3'd5, 32'd5);
        push_r(3'd6, 32'd3);
        pulse(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        pulse(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        pulse(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (n < 200 && rd_seen < base + 4) begin
            @(negedge clk); #1;
            n++;
        end
        chk("s6_reached_rd_ev", rd_seen - base, 4);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_zero_outputs("s6_reset");
        chk("s6_no_early_write", exp_q.size(), 0);
        rd_resp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("s6_busy_after", busy, 1'b0);
        chk("s6_res_valid_after", res_valid, 1'b0);
        chk("s6_bt_after", avm_begintransfer, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
